// File: rtl/soc_sysid_regs.sv
// System-ID register slave: design ID, timestamp, caps, scratch, 64-bit uptime with a
// coherent hi/lo snapshot and user build words, returned through a fixed-latency read pipeline.
module soc_sysid_regs #(
  parameter logic [31:0]  ID_VALUE     = 32'h0000_0000,
  parameter logic [31:0]  TIMESTAMP    = 32'd0,
  parameter int           NUM_USER     = 4,
  parameter logic [511:0] USER_WORDS   = {16{32'h0}},
  parameter int           READ_LATENCY = 1,
  parameter int           ADDR_W       = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              waitrequest
);

  localparam int NUM_WORDS = 6 + NUM_USER;

  if (NUM_USER > 16 || NUM_USER < 0) begin : gNumUserCheck
    $error("soc_sysid_regs: NUM_USER must be 0..16");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : gLatencyCheck
    $error("soc_sysid_regs: READ_LATENCY must be 1..4");
  end
  if ((64'(1) << ADDR_W) < 64'(NUM_WORDS)) begin : gAddrWidthCheck
    $error("soc_sysid_regs: ADDR_W too small for the register map");
  end

  logic [63:0] uptime_q, uptime_d;
  logic [31:0] snapHi_q, snapHi_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] pipeData_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipeValid_q;

  logic        readAccept;
  logic        writeScratch;
  logic [31:0] addrWide;
  logic [3:0]  userIdx;
  logic [31:0] caps;
  logic [31:0] readMux;

  // A read always wins over a simultaneous write; only the scratch word is writable.
  assign readAccept   = read;
  assign writeScratch = write && !read && (address == ADDR_W'(3));
  assign addrWide     = 32'(address);
  assign userIdx      = 4'(addrWide - 32'd6);
  assign caps         = {16'h0, 4'(READ_LATENCY), 4'h0, 8'(NUM_USER)};
  assign waitrequest  = 1'b0;

  always_comb begin
    readMux = 32'h0;
    case (addrWide)
      32'd0:   readMux = ID_VALUE;
      32'd1:   readMux = TIMESTAMP;
      32'd2:   readMux = caps;
      32'd3:   readMux = scratch_q;
      32'd4:   readMux = uptime_q[31:0];
      32'd5:   readMux = snapHi_q;
      default: begin
        if (addrWide >= 32'd6 && addrWide < 32'(NUM_WORDS)) begin
          readMux = USER_WORDS[{userIdx, 5'd0} +: 32];
        end
      end
    endcase
  end

  // The hi half is latched by the lo read so a later hi read matches across a lo carry.
  always_comb begin
    uptime_d  = uptime_q + 64'd1;
    snapHi_d  = snapHi_q;
    scratch_d = scratch_q;
    if (readAccept && address == ADDR_W'(4)) begin
      snapHi_d = uptime_q[63:32];
    end
    if (writeScratch) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch_d[8*i +: 8] = writedata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q  <= 64'd0;
      snapHi_q  <= 32'd0;
      scratch_q <= 32'd0;
    end else begin
      uptime_q  <= uptime_d;
      snapHi_q  <= snapHi_d;
      scratch_q <= scratch_d;
    end
  end

  // Data stages load only behind a valid so the output stage holds its last value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipeValid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipeData_q[i] <= 32'd0;
      end
    end else begin
      pipeValid_q[0] <= readAccept;
      if (readAccept) begin
        pipeData_q[0] <= readMux;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        if (pipeValid_q[i-1]) begin
          pipeData_q[i] <= pipeData_q[i-1];
        end
      end
    end
  end

  assign readdata      = pipeData_q[READ_LATENCY-1];
  assign readdatavalid = pipeValid_q[READ_LATENCY-1];

endmodule
